memory_access: RTL and testbench
================================

# memory_access

Pipeline stage directly downstream of `execution`: consumes its registered control bundle, ALU/FPU `result` and `register_data`, and performs the data-memory load/store, the UART receive read, and branch/jump resolution. Produces a registered write-back bundle for the register file and a PC redirect for fetch. Multi-cycle operations (loads, UART reads) stall the stage through a small FSM and raise `busy` for the hazard unit.

## Interface
- `INST_MEM_WIDTH`, 2, instruction-address width, matching the upstream stages
- `DATA_MEM_WIDTH`, 10, data-memory word-address width
- `MEM_LATENCY`, 2, cycles from `dmem_en` to valid `dmem_rdata`; legal range 1..7
- `CLK` in 1: the single clock
- `reset` in 1: synchronous, active-high
- `valid`, `distinct`, `AorF`, `RegWrite`, `MemWrite`, `MemRead`, `UARTtoReg` in 1 each: execution outputs
- `MemtoReg`, `Branch` in 2 each: execution outputs
- `register_data`, `result` in 32: store data and ALU/FPU result
- `rdist` in 5: destination register
- `inst_index` in 26: jump target field
- `pc`, `pc1`, `pc2` in INST_MEM_WIDTH: own PC, PC+1, branch target
- `dmem_en`, `dmem_we` out 1; `dmem_addr` out DATA_MEM_WIDTH; `dmem_wdata` out 32; `dmem_rdata` in 32
- `uart_rx_valid` in 1; `uart_rx_data` in 8; `uart_rx_ready` out 1: byte is consumed when valid && ready
- `busy` out 1: stage not accepting; combinational from state
- `wb_valid`, `wb_RegWrite`, `wb_AorF` out 1; `wb_rdist` out 5; `wb_data` out 32
- `redirect` out 1; `redirect_pc` out INST_MEM_WIDTH
- `overrun` out 1: sticky, set when `valid` arrives while `busy`

## Operation
- FSM states IDLE, MEM_WAIT, UART_WAIT. `busy` = (state != IDLE).
- Accept when `valid && !busy`. If `valid && busy`: input dropped, `overrun` <= 1 (cleared only by reset).
- Address: `dmem_addr` = `result[DATA_MEM_WIDTH+1:2]` (byte address, word aligned; low 2 bits ignored). `dmem_wdata` = `register_data`.
- Store (`MemWrite`): `dmem_en`=`dmem_we`=1 for the accept cycle only, combinational from inputs; stay IDLE; no register write regardless of `RegWrite`.
- Load (`MemRead`): `dmem_en`=1, `dmem_we`=0 in accept cycle; go MEM_WAIT, down-counter = MEM_LATENCY-1; at 0 capture `dmem_rdata` into `wb_data`, return IDLE. `MemRead && MemWrite` together: store wins.
- UART (`UARTtoReg`): go UART_WAIT; `uart_rx_ready`=1 only in UART_WAIT; on `uart_rx_valid` `wb_data` <= zero-extended byte, return IDLE.
- Otherwise `wb_data` per `MemtoReg`: 00 `result`, 10 zero-extended `pc1`, 01/11 `result`.
- Branch (evaluated at accept, all kinds): 11 none; 00 conditional, taken iff (`result`==0) XOR `distinct`, target `pc2`; 01 jump, target `inst_index[INST_MEM_WIDTH-1:0]`; 10 jump register, target `result[INST_MEM_WIDTH-1:0]`.
- `wb_RegWrite`, `wb_rdist`, `wb_AorF` latched from inputs at accept; `wb_valid` pulses one cycle when the instruction completes.

## Timing
- Reset values: all outputs 0, state IDLE, counter 0, `overrun` 0.
- Non-memory/store: `wb_valid`, `wb_data`, `redirect`, `redirect_pc` registered, valid the cycle after accept (latency 1). `redirect` is a one-cycle pulse.
- Load: `wb_valid` at accept + MEM_LATENCY + 1... precisely: capture on the edge MEM_LATENCY cycles after accept, `wb_valid` high the following cycle; `busy` high for MEM_LATENCY cycles.
- UART: `wb_valid` the cycle after the handshake; unbounded wait; `busy` high throughout.
- Back-to-back non-memory instructions every cycle sustain `wb_valid` continuously.
- Redirect for load/UART instructions with Branch != 11 issues at accept, not at completion.
- Reset mid-MEM_WAIT/UART_WAIT: return IDLE next edge, no `wb_valid`, pending UART byte not consumed.

## Structure
- Shared package: FSM state enum, `Branch` encodings (BR_COND, BR_J, BR_JR, BR_NONE), `MemtoReg` encodings.
- One natural sub-module: `branch_resolve` (combinational: `Branch`, `distinct`, `result`, `pc2`, `inst_index` -> `redirect`, `redirect_pc`).

## Test plan
- ALU op, `result`=0x1234, `RegWrite`=1, `rdist`=5 -> next cycle `wb_valid`=1, `wb_data`=0x1234, `wb_rdist`=5, `redirect`=0.
- Store `result`=0x10, `register_data`=0xDEAD -> `dmem_en`=`dmem_we`=1, `dmem_addr`=4, `dmem_wdata`=0xDEAD; `wb_RegWrite`=0.
- Load with MEM_LATENCY=2, `dmem_rdata`=0xCAFE -> `busy` 2 cycles, `wb_data`=0xCAFE with `wb_valid` the cycle after; second `valid` during busy sets `overrun`.
- Branch 00, `result`=0, `distinct`=0, `pc2`=3 -> `redirect`=1, `redirect_pc`=3; same with `distinct`=1 -> `redirect`=0.
- UART read, `uart_rx_valid` raised after 5 cycles with 0x41 -> `uart_rx_ready` high during wait, `wb_data`=0x00000041.
- Reset asserted during MEM_WAIT -> next cycle `busy`=0, `wb_valid`=0, all outputs 0.

Source files
------------

// File: rtl/memory_access_pkg.sv
// Shared encodings, widths and the write-back payload for the memory-access stage.
package memory_access_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned RDIST_W = 5;
  localparam int unsigned BYTE_W  = 8;
  localparam int unsigned INDEX_W = 26;
  localparam int unsigned CNT_W   = 3;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_MEM_WAIT  = 2'd1,
    ST_UART_WAIT = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    BR_COND = 2'b00,
    BR_J    = 2'b01,
    BR_JR   = 2'b10,
    BR_NONE = 2'b11
  } branch_e;

  typedef enum logic [1:0] {
    M2R_RESULT     = 2'b00,
    M2R_RESULT_ALT = 2'b01,
    M2R_PC1        = 2'b10,
    M2R_RESULT_HI  = 2'b11
  } memtoreg_e;

  typedef struct packed {
    logic               valid;
    logic               reg_write;
    logic               aorf;
    logic [RDIST_W-1:0] rdist;
    logic [WORD_W-1:0]  data;
  } wb_t;

endpackage

// File: rtl/memory_access_branch_resolve.sv
// Combinational branch/jump resolution: decides whether fetch is redirected and where.
module memory_access_branch_resolve
  import memory_access_pkg::*;
#(
  parameter int unsigned INST_MEM_WIDTH = 2
) (
  input  logic [1:0]                i_Branch,
  input  logic                      i_distinct,
  input  logic [WORD_W-1:0]         i_result,
  input  logic [INST_MEM_WIDTH-1:0] i_pc2,
  input  logic [INDEX_W-1:0]        i_inst_index,
  output logic                      o_redirect_c,
  output logic [INST_MEM_WIDTH-1:0] o_redirect_pc_c
);

  // Only the low bits of the jump field address instruction memory.
  logic w_unused;
  assign w_unused = ^i_inst_index[INDEX_W-1:INST_MEM_WIDTH];

  always_comb begin
    o_redirect_c    = 1'b0;
    o_redirect_pc_c = '0;
    unique case (branch_e'(i_Branch))
      BR_COND: begin
        o_redirect_c    = (i_result == '0) ^ i_distinct;
        o_redirect_pc_c = i_pc2;
      end
      BR_J: begin
        o_redirect_c    = 1'b1;
        o_redirect_pc_c = i_inst_index[INST_MEM_WIDTH-1:0];
      end
      BR_JR: begin
        o_redirect_c    = 1'b1;
        o_redirect_pc_c = i_result[INST_MEM_WIDTH-1:0];
      end
      default: begin
        o_redirect_c    = 1'b0;
        o_redirect_pc_c = '0;
      end
    endcase
  end

endmodule

// File: rtl/memory_access.sv
// Memory-access pipeline stage: data-memory load/store, UART receive read, branch
// resolution, and a registered write-back bundle; multi-cycle ops stall via a small FSM.
module memory_access
  import memory_access_pkg::*;
#(
  parameter int unsigned INST_MEM_WIDTH = 2,
  parameter int unsigned DATA_MEM_WIDTH = 10,
  parameter int unsigned MEM_LATENCY    = 2
) (
  input  logic                      i_CLK,
  input  logic                      i_reset,
  input  logic                      i_valid,
  input  logic                      i_distinct,
  input  logic                      i_AorF,
  input  logic                      i_RegWrite,
  input  logic                      i_MemWrite,
  input  logic                      i_MemRead,
  input  logic                      i_UARTtoReg,
  input  logic [1:0]                i_MemtoReg,
  input  logic [1:0]                i_Branch,
  input  logic [WORD_W-1:0]         i_register_data,
  input  logic [WORD_W-1:0]         i_result,
  input  logic [RDIST_W-1:0]        i_rdist,
  input  logic [INDEX_W-1:0]        i_inst_index,
  input  logic [INST_MEM_WIDTH-1:0] i_pc,
  input  logic [INST_MEM_WIDTH-1:0] i_pc1,
  input  logic [INST_MEM_WIDTH-1:0] i_pc2,
  output logic                      o_dmem_en,
  output logic                      o_dmem_we,
  output logic [DATA_MEM_WIDTH-1:0] o_dmem_addr,
  output logic [WORD_W-1:0]         o_dmem_wdata,
  input  logic [WORD_W-1:0]         i_dmem_rdata,
  input  logic                      i_uart_rx_valid,
  input  logic [BYTE_W-1:0]         i_uart_rx_data,
  output logic                      o_uart_rx_ready,
  output logic                      o_busy,
  output logic                      o_wb_valid,
  output logic                      o_wb_RegWrite,
  output logic                      o_wb_AorF,
  output logic [RDIST_W-1:0]        o_wb_rdist,
  output logic [WORD_W-1:0]         o_wb_data,
  output logic                      o_redirect,
  output logic [INST_MEM_WIDTH-1:0] o_redirect_pc,
  output logic                      o_overrun
);

  state_e                    r_state;
  logic [CNT_W-1:0]          r_cnt;
  wb_t                       r_wb;
  logic                      r_redirect;
  logic [INST_MEM_WIDTH-1:0] r_redirect_pc;
  logic                      r_overrun;

  state_e                    w_state_nxt;
  logic [CNT_W-1:0]          w_cnt_nxt;
  wb_t                       w_wb_nxt;
  logic                      w_redirect_nxt;
  logic [INST_MEM_WIDTH-1:0] w_redirect_pc_nxt;
  logic                      w_overrun_nxt;
  logic                      w_busy;
  logic                      w_accept;
  logic                      w_br_redirect;
  logic [INST_MEM_WIDTH-1:0] w_br_pc;
  logic [WORD_W-1:0]         w_alu_data;
  logic                      w_unused;

  assign w_unused   = ^i_pc;
  assign w_busy     = (r_state != ST_IDLE);
  assign w_accept   = i_valid & ~w_busy & ~i_reset;
  assign w_alu_data = (memtoreg_e'(i_MemtoReg) == M2R_PC1) ? WORD_W'(i_pc1) : i_result;

  memory_access_branch_resolve #(
    .INST_MEM_WIDTH (INST_MEM_WIDTH)
  ) u_branch_resolve (
    .i_Branch        (i_Branch),
    .i_distinct      (i_distinct),
    .i_result        (i_result),
    .i_pc2           (i_pc2),
    .i_inst_index    (i_inst_index),
    .o_redirect_c    (w_br_redirect),
    .o_redirect_pc_c (w_br_pc)
  );

  // Memory strobes are issued in the accept cycle itself; a store overrides a load.
  assign o_dmem_en       = w_accept & (i_MemWrite | i_MemRead);
  assign o_dmem_we       = w_accept & i_MemWrite;
  assign o_dmem_addr     = i_result[DATA_MEM_WIDTH+1:2];
  assign o_dmem_wdata    = i_register_data;
  assign o_uart_rx_ready = (r_state == ST_UART_WAIT) & ~i_reset;
  assign o_busy          = w_busy;

  always_ff @(posedge i_CLK) begin
    if (i_reset) begin
      r_state       <= ST_IDLE;
      r_cnt         <= '0;
      r_wb          <= '0;
      r_redirect    <= 1'b0;
      r_redirect_pc <= '0;
      r_overrun     <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_cnt         <= w_cnt_nxt;
      r_wb          <= w_wb_nxt;
      r_redirect    <= w_redirect_nxt;
      r_redirect_pc <= w_redirect_pc_nxt;
      r_overrun     <= w_overrun_nxt;
    end
  end

  always_comb begin
    w_state_nxt       = r_state;
    w_cnt_nxt         = r_cnt;
    w_wb_nxt          = r_wb;
    w_wb_nxt.valid    = 1'b0;
    w_redirect_nxt    = 1'b0;
    w_redirect_pc_nxt = r_redirect_pc;
    w_overrun_nxt     = r_overrun | (i_valid & w_busy);
    unique case (r_state)
      ST_IDLE: begin
        if (i_valid) begin
          w_wb_nxt.reg_write = i_RegWrite & ~i_MemWrite;
          w_wb_nxt.aorf      = i_AorF;
          w_wb_nxt.rdist     = i_rdist;
          w_wb_nxt.data      = w_alu_data;
          w_redirect_nxt     = w_br_redirect;
          w_redirect_pc_nxt  = w_br_pc;
          if (i_MemWrite) begin
            w_wb_nxt.valid = 1'b1;
          end else if (i_MemRead) begin
            w_state_nxt = ST_MEM_WAIT;
            w_cnt_nxt   = CNT_W'(MEM_LATENCY - 1);
          end else if (i_UARTtoReg) begin
            w_state_nxt = ST_UART_WAIT;
          end else begin
            w_wb_nxt.valid = 1'b1;
          end
        end
      end
      ST_MEM_WAIT: begin
        if (r_cnt == '0) begin
          w_wb_nxt.data  = i_dmem_rdata;
          w_wb_nxt.valid = 1'b1;
          w_state_nxt    = ST_IDLE;
        end else begin
          w_cnt_nxt = r_cnt - CNT_W'(1);
        end
      end
      ST_UART_WAIT: begin
        if (i_uart_rx_valid) begin
          w_wb_nxt.data  = WORD_W'(i_uart_rx_data);
          w_wb_nxt.valid = 1'b1;
          w_state_nxt    = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  assign o_wb_valid    = r_wb.valid;
  assign o_wb_RegWrite = r_wb.reg_write;
  assign o_wb_AorF     = r_wb.aorf;
  assign o_wb_rdist    = r_wb.rdist;
  assign o_wb_data     = r_wb.data;
  assign o_redirect    = r_redirect;
  assign o_redirect_pc = r_redirect_pc;
  assign o_overrun     = r_overrun;

endmodule

// File: tb/tb_memory_access.sv
// Directed + randomized bench for memory_access against a behavioural reference model.
module tb_memory_access;

  localparam int unsigned IW  = 2;
  localparam int unsigned DW  = 10;
  localparam int unsigned LAT = 2;

  typedef struct packed {
    logic          distinct;
    logic          aorf;
    logic          regwrite;
    logic [1:0]    m2r;
    logic [1:0]    br;
    logic [31:0]   res;
    logic [31:0]   sdata;
    logic [4:0]    rdist;
    logic [25:0]   idx;
    logic [IW-1:0] pc1;
    logic [IW-1:0] pc2;
  } ins_t;

  logic          clk = 1'b0;
  logic          reset, valid, distinct, AorF, RegWrite, MemWrite, MemRead, UARTtoReg;
  logic [1:0]    MemtoReg, Branch;
  logic [31:0]   register_data, result, dmem_rdata;
  logic [4:0]    rdist;
  logic [25:0]   inst_index;
  logic [IW-1:0] pc, pc1, pc2;
  logic          uart_rx_valid;
  logic [7:0]    uart_rx_data;

  logic          dmem_en, dmem_we, uart_rx_ready, busy;
  logic [DW-1:0] dmem_addr;
  logic [31:0]   dmem_wdata, wb_data;
  logic          wb_valid, wb_RegWrite, wb_AorF, redirect, overrun;
  logic [4:0]    wb_rdist;
  logic [IW-1:0] redirect_pc;

  int   total = 0;
  int   bad   = 0;
  logic exp_overrun = 1'b0;

  always #5 clk = ~clk;

  memory_access #(
    .INST_MEM_WIDTH (IW),
    .DATA_MEM_WIDTH (DW),
    .MEM_LATENCY    (LAT)
  ) dut (
    .i_CLK           (clk),
    .i_reset         (reset),
    .i_valid         (valid),
    .i_distinct      (distinct),
    .i_AorF          (AorF),
    .i_RegWrite      (RegWrite),
    .i_MemWrite      (MemWrite),
    .i_MemRead       (MemRead),
    .i_UARTtoReg     (UARTtoReg),
    .i_MemtoReg      (MemtoReg),
    .i_Branch        (Branch),
    .i_register_data (register_data),
    .i_result        (result),
    .i_rdist         (rdist),
    .i_inst_index    (inst_index),
    .i_pc            (pc),
    .i_pc1           (pc1),
    .i_pc2           (pc2),
    .o_dmem_en       (dmem_en),
    .o_dmem_we       (dmem_we),
    .o_dmem_addr     (dmem_addr),
    .o_dmem_wdata    (dmem_wdata),
    .i_dmem_rdata    (dmem_rdata),
    .i_uart_rx_valid (uart_rx_valid),
    .i_uart_rx_data  (uart_rx_data),
    .o_uart_rx_ready (uart_rx_ready),
    .o_busy          (busy),
    .o_wb_valid      (wb_valid),
    .o_wb_RegWrite   (wb_RegWrite),
    .o_wb_AorF       (wb_AorF),
    .o_wb_rdist      (wb_rdist),
    .o_wb_data       (wb_data),
    .o_redirect      (redirect),
    .o_redirect_pc   (redirect_pc),
    .o_overrun       (overrun)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference model: values the stage must produce, straight from the instruction fields.
  function automatic logic [31:0] ref_data(input ins_t n);
    return (n.m2r == 2'b10) ? 32'(n.pc1) : n.res;
  endfunction

  function automatic logic ref_taken(input ins_t n);
    case (n.br)
      2'b00:   return (n.res == 32'd0) != n.distinct;
      2'b01:   return 1'b1;
      2'b10:   return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [IW-1:0] ref_target(input ins_t n);
    logic [25:0] idx;
    logic [31:0] res;
    idx = n.idx;
    res = n.res;
    case (n.br)
      2'b00:   return n.pc2;
      2'b01:   return idx[IW-1:0];
      default: return res[IW-1:0];
    endcase
  endfunction

  function automatic ins_t rand_ins();
    ins_t n;
    n.distinct = 1'($urandom);
    n.aorf     = 1'($urandom);
    n.regwrite = 1'($urandom);
    n.m2r      = 2'($urandom);
    n.br       = 2'($urandom);
    n.res      = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
    n.sdata    = $urandom;
    n.rdist    = 5'($urandom);
    n.idx      = 26'($urandom);
    n.pc1      = IW'($urandom);
    n.pc2      = IW'($urandom);
    return n;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    valid = 0; distinct = 0; AorF = 0; RegWrite = 0; MemWrite = 0; MemRead = 0;
    UARTtoReg = 0; MemtoReg = 0; Branch = 2'b11; register_data = 0; result = 0;
    rdist = 0; inst_index = 0; pc = 0; pc1 = 0; pc2 = 0;
  endtask

  task automatic apply(input ins_t n, input logic mw, input logic mr, input logic ua);
    valid = 1; distinct = n.distinct; AorF = n.aorf; RegWrite = n.regwrite;
    MemWrite = mw; MemRead = mr; UARTtoReg = ua; MemtoReg = n.m2r; Branch = n.br;
    register_data = n.sdata; result = n.res; rdist = n.rdist; inst_index = n.idx;
    pc = IW'($urandom); pc1 = n.pc1; pc2 = n.pc2;
  endtask

  task automatic check_redirect(input string tag, input ins_t n);
    check({tag, ".redirect"}, 32'(redirect), 32'(ref_taken(n)));
    if (ref_taken(n)) check({tag, ".redirect_pc"}, 32'(redirect_pc), 32'(ref_target(n)));
  endtask

  task automatic check_wb(input string tag, input ins_t n, input logic [31:0] data,
                          input logic regw);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd1);
    check({tag, ".wb_data"}, wb_data, data);
    check({tag, ".wb_rdist"}, 32'(wb_rdist), 32'(n.rdist));
    check({tag, ".wb_RegWrite"}, 32'(wb_RegWrite), 32'(regw));
    check({tag, ".wb_AorF"}, 32'(wb_AorF), 32'(n.aorf));
    check({tag, ".overrun"}, 32'(overrun), 32'(exp_overrun));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, ".busy"}, 32'(busy), 32'd0);
    check({tag, ".wb_valid"}, 32'(wb_valid), 32'd0);
    check({tag, ".wb_RegWrite"}, 32'(wb_RegWrite), 32'd0);
    check({tag, ".wb_AorF"}, 32'(wb_AorF), 32'd0);
    check({tag, ".wb_rdist"}, 32'(wb_rdist), 32'd0);
    check({tag, ".wb_data"}, wb_data, 32'd0);
    check({tag, ".redirect"}, 32'(redirect), 32'd0);
    check({tag, ".redirect_pc"}, 32'(redirect_pc), 32'd0);
    check({tag, ".overrun"}, 32'(overrun), 32'd0);
    check({tag, ".uart_rx_ready"}, 32'(uart_rx_ready), 32'd0);
    check({tag, ".dmem_en"}, 32'(dmem_en), 32'd0);
    check({tag, ".dmem_we"}, 32'(dmem_we), 32'd0);
    check({tag, ".dmem_addr"}, 32'(dmem_addr), 32'd0);
    check({tag, ".dmem_wdata"}, dmem_wdata, 32'd0);
  endtask

  task automatic do_alu(input string tag, input ins_t n);
    apply(n, 0, 0, 0);
    #1;
    check({tag, ".dmem_en"}, 32'(dmem_en), 32'd0);
    tick();
    idle_inputs();
    check_wb(tag, n, ref_data(n), n.regwrite);
    check_redirect(tag, n);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_store(input string tag, input ins_t n, input logic also_read);
    apply(n, 1, also_read, 0);
    #1;
    check({tag, ".dmem_en"}, 32'(dmem_en), 32'd1);
    check({tag, ".dmem_we"}, 32'(dmem_we), 32'd1);
    check({tag, ".dmem_addr"}, 32'(dmem_addr), 32'(n.res[DW+1:2]));
    check({tag, ".dmem_wdata"}, dmem_wdata, n.sdata);
    tick();
    idle_inputs();
    #1;
    check({tag, ".dmem_en_after"}, 32'(dmem_en), 32'd0);
    check_wb(tag, n, ref_data(n), 1'b0);
    check_redirect(tag, n);
    check({tag, ".busy"}, 32'(busy), 32'd0);
  endtask

  task automatic do_load(input string tag, input ins_t n, input logic [31:0] rdv,
                         input logic poke);
    ins_t junk;
    apply(n, 0, 1, 0);
    dmem_rdata = ~rdv;
    #1;
    check({tag, ".dmem_en"}, 32'(dmem_en), 32'd1);
    check({tag, ".dmem_we"}, 32'(dmem_we), 32'd0);
    check({tag, ".dmem_addr"}, 32'(dmem_addr), 32'(n.res[DW+1:2]));
    tick();
    idle_inputs();
    check({tag, ".busy0"}, 32'(busy), 32'd1);
    check({tag, ".wb_valid0"}, 32'(wb_valid), 32'd0);
    check_redirect({tag, ".accept"}, n);
    for (int i = 1; i <= int'(LAT); i++) begin
      if (i == int'(LAT)) dmem_rdata = rdv;
      if (poke && i == 1) begin
        junk = rand_ins();
        apply(junk, 0, 0, 0);
        exp_overrun = 1'b1;
      end
      tick();
      idle_inputs();
      if (i < int'(LAT)) begin
        check({tag, ".busy_wait"}, 32'(busy), 32'd1);
        check({tag, ".wb_valid_wait"}, 32'(wb_valid), 32'd0);
        check({tag, ".redirect_wait"}, 32'(redirect), 32'd0);
        check({tag, ".overrun_wait"}, 32'(overrun), 32'(exp_overrun));
      end
    end
    dmem_rdata = ~rdv;
    check_wb(tag, n, rdv, n.regwrite);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    tick();
    check({tag, ".wb_valid_pulse"}, 32'(wb_valid), 32'd0);
  endtask

  task automatic do_uart(input string tag, input ins_t n, input int waits,
                         input logic [7:0] b);
    apply(n, 0, 0, 1);
    #1;
    check({tag, ".dmem_en"}, 32'(dmem_en), 32'd0);
    check({tag, ".ready_idle"}, 32'(uart_rx_ready), 32'd0);
    tick();
    idle_inputs();
    check({tag, ".busy0"}, 32'(busy), 32'd1);
    check_redirect({tag, ".accept"}, n);
    for (int i = 0; i < waits; i++) begin
      uart_rx_data = 8'($urandom);
      #1;
      check({tag, ".ready_wait"}, 32'(uart_rx_ready), 32'd1);
      check({tag, ".wb_valid_wait"}, 32'(wb_valid), 32'd0);
      check({tag, ".busy_wait"}, 32'(busy), 32'd1);
      tick();
    end
    uart_rx_valid = 1;
    uart_rx_data  = b;
    #1;
    check({tag, ".ready_hs"}, 32'(uart_rx_ready), 32'd1);
    tick();
    uart_rx_valid = 0;
    uart_rx_data  = 8'($urandom);
    check_wb(tag, n, 32'(b), n.regwrite);
    check({tag, ".busy_done"}, 32'(busy), 32'd0);
    check({tag, ".ready_done"}, 32'(uart_rx_ready), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    ins_t n, cur, prev;
    reset = 1;
    idle_inputs();
    dmem_rdata = 0;
    uart_rx_valid = 0;
    uart_rx_data = 0;
    tick();
    tick();
    check_all_zero("reset");
    reset = 0;

    // ALU op from the test plan
    n = rand_ins();
    n.res = 32'h1234; n.regwrite = 1; n.rdist = 5'd5; n.m2r = 2'b00; n.br = 2'b11;
    do_alu("alu_dir", n);
    check("alu_dir.data_const", wb_data, 32'h0000_1234);

    // MemtoReg=10 selects zero-extended PC+1
    n = rand_ins();
    n.m2r = 2'b10; n.pc1 = IW'(3); n.res = 32'hFFFF_FFF0;
    do_alu("alu_pc1", n);
    check("alu_pc1.data_const", wb_data, 32'd3);

    // Back-to-back ALU instructions keep wb_valid high every cycle
    cur = rand_ins();
    apply(cur, 0, 0, 0);
    for (int i = 0; i < 20; i++) begin
      prev = cur;
      tick();
      if (i < 19) begin
        cur = rand_ins();
        apply(cur, 0, 0, 0);
      end else begin
        idle_inputs();
      end
      check_wb("b2b", prev, ref_data(prev), prev.regwrite);
      check_redirect("b2b", prev);
    end

    // Store from the test plan, then store+load (store wins)
    n = rand_ins();
    n.res = 32'h10; n.sdata = 32'hDEAD; n.regwrite = 1; n.br = 2'b11;
    do_store("st_dir", n, 1'b0);
    check("st_dir.addr_const", 32'(n.res[DW+1:2]), 32'd4);
    do_store("st_rd", rand_ins(), 1'b1);

    // Load from the test plan with an extra valid during busy
    n = rand_ins();
    do_load("ld_dir", n, 32'h0000_CAFE, 1'b1);
    check("ld_dir.overrun_sticky", 32'(overrun), 32'd1);

    // Conditional branch taken / not taken, plus jumps
    n = rand_ins();
    n.br = 2'b00; n.res = 32'd0; n.distinct = 0; n.pc2 = IW'(3);
    do_alu("br_taken", n);
    check("br_taken.redirect_const", 32'(redirect), 32'd1);
    check("br_taken.pc_const", 32'(redirect_pc), 32'd3);
    n.distinct = 1;
    do_alu("br_not", n);
    check("br_not.redirect_const", 32'(redirect), 32'd0);
    n = rand_ins();
    n.br = 2'b01; n.idx = 26'h3FF_FFF2;
    do_alu("br_j", n);
    check("br_j.pc_const", 32'(redirect_pc), 32'd2);
    n = rand_ins();
    n.br = 2'b10; n.res = 32'h8000_0001;
    do_alu("br_jr", n);
    check("br_jr.pc_const", 32'(redirect_pc), 32'd1);
    tick();
    check("br.pulse", 32'(redirect), 32'd0);

    // UART read from the test plan
    n = rand_ins();
    do_uart("uart_dir", n, 5, 8'h41);
    check("uart_dir.data_const", wb_data, 32'h0000_0041);

    // Randomized mix of all instruction kinds
    for (int i = 0; i < 40; i++) begin
      n = rand_ins();
      case ($urandom_range(0, 3))
        0: do_alu("rnd_alu", n);
        1: do_store("rnd_st", n, 1'($urandom));
        2: do_load("rnd_ld", n, $urandom, 1'b0);
        default: do_uart("rnd_uart", n, int'($urandom_range(0, 4)), 8'($urandom));
      endcase
      if ($urandom_range(0, 2) == 0) tick();
    end

    // Reset in the middle of a load wait
    n = rand_ins();
    apply(n, 0, 1, 0);
    tick();
    idle_inputs();
    dmem_rdata = 32'hBEEF_0001;
    reset = 1;
    tick();
    exp_overrun = 1'b0;
    check_all_zero("rst_ld");
    reset = 0;
    tick();
    check("rst_ld.wb_valid_after", 32'(wb_valid), 32'd0);
    tick();
    check("rst_ld.wb_valid_after2", 32'(wb_valid), 32'd0);

    // Reset in the middle of a UART wait; the offered byte must not be taken
    n = rand_ins();
    apply(n, 0, 0, 1);
    tick();
    idle_inputs();
    uart_rx_valid = 1;
    uart_rx_data  = 8'h55;
    reset = 1;
    #1;
    check("rst_uart.ready_in_reset", 32'(uart_rx_ready), 32'd0);
    tick();
    check_all_zero("rst_uart");
    reset = 0;
    #1;
    check("rst_uart.ready_after", 32'(uart_rx_ready), 32'd0);
    tick();
    check("rst_uart.wb_valid_after", 32'(wb_valid), 32'd0);
    uart_rx_valid = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
